// File: rtl/endec_job_ctrl.sv
// endec_job_ctrl: one-job-at-a-time sequencer that configures, resets and drives the endec core and returns its result
module endec_job_ctrl #(
    parameter int CR_W    = 3,
    parameter int K_W     = 9,
    parameter int TB_W    = 16,
    parameter int FL      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic                 job_mode,
    input  logic                 job_code_rate,
    input  logic [1:0]           job_constr_len,
    input  logic [CR_W*K_W-1:0]  job_gen_poly,
    input  logic [TB_W-1:0]      job_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [FL*CR_W-1:0]   res_data,
    output logic                 res_err,
    output logic                 core_rst_n,
    output logic                 core_en,
    output logic                 core_code_rate,
    output logic [1:0]           core_constr_len,
    output logic [K_W-1:0]       core_gen_poly [CR_W],
    output logic                 core_mode_sel,
    output logic                 core_encoder_bit,
    output logic [TB_W-1:0]      core_decoder_data_frame,
    input  logic [CR_W-1:0]      core_encoder_data,
    input  logic                 core_encoder_done,
    input  logic [FL-1:0]        core_decoder_data,
    input  logic                 core_decoder_done
);
    localparam int CNT_W = $clog2(FL);
    localparam int TO_W = $clog2(TIMEOUT);
    localparam int RD_W = FL * CR_W;
    localparam logic ENCODE_MODE = 1'b0;

    typedef enum logic [2:0] {IDLE, CRST, ENC, DEC, RESP} state_t;
    state_t state, state_d;

    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0] tmo;
    logic [CR_W*K_W-1:0] gen_q;
    logic accept, done, expire;

    for (genvar g = 0; g < CR_W; g++) begin : g_poly
        assign core_gen_poly[g] = gen_q[g*K_W +: K_W];
    end

    assign accept = (state == IDLE) && job_valid;
    assign done = ((state == ENC) && core_encoder_done) || ((state == DEC) && core_decoder_done);
    assign expire = ((state == ENC) || (state == DEC)) && !done && (tmo == TO_W'(TIMEOUT - 1));
    assign job_ready = (state == IDLE);
    assign res_valid = (state == RESP);
    assign core_en = (state == ENC) || (state == DEC);
    // the core stays in reset during the per-job pulse and after an abort
    assign core_rst_n = rst && (state != CRST) && !((state == RESP) && res_err);
    assign core_encoder_bit = (state == ENC) && core_decoder_data_frame[cnt];

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: state_d = job_valid ? CRST : IDLE;
            CRST: state_d = (core_mode_sel == ENCODE_MODE) ? ENC : DEC;
            ENC:  state_d = ((done && cnt == '0) || expire) ? RESP : ENC;
            DEC:  state_d = (done || expire) ? RESP : DEC;
            RESP: state_d = res_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            res_data <= '0;
            res_err <= 1'b0;
            cnt <= '0;
            tmo <= '0;
            gen_q <= '0;
            core_code_rate <= 1'b0;
            core_constr_len <= '0;
            core_mode_sel <= 1'b0;
            core_decoder_data_frame <= '0;
        end else if (accept) begin
            res_data <= '0;
            res_err <= 1'b0;
            gen_q <= job_gen_poly;
            core_code_rate <= job_code_rate;
            core_constr_len <= job_constr_len;
            core_mode_sel <= job_mode;
            core_decoder_data_frame <= job_data;
        end else if (state == CRST) begin
            cnt <= CNT_W'(FL - 1);
            tmo <= '0;
        end else if (core_en) begin
            tmo <= done ? '0 : tmo + 1'b1;
            if (expire) res_err <= 1'b1;
            if (done && state == ENC) begin
                res_data <= {res_data[RD_W-CR_W-1:0], core_encoder_data};
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
            if (done && state == DEC) res_data <= {{(RD_W-FL){1'b0}}, core_decoder_data};
        end
    end
endmodule

// File: tb/tb_endec_job_ctrl.sv
// tb_endec_job_ctrl: directed bench with a small rate-1/2 K=3 encoder stub and an xor-fold decoder stub as the core
module tb_endec_job_ctrl;
    localparam int CR_W = 3;
    localparam int K_W = 9;
    localparam int TB_W = 16;
    localparam int FL = 8;
    localparam int TIMEOUT = 64;

    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    logic job_valid = 1'b0, job_mode = 1'b0, job_code_rate = 1'b0, res_ready = 1'b0;
    logic [1:0] job_constr_len = '0;
    logic [CR_W*K_W-1:0] job_gen_poly = '0;
    logic [TB_W-1:0] job_data = '0;
    logic job_ready, res_valid, res_err, core_rst_n, core_en, core_code_rate, core_mode_sel, core_encoder_bit;
    logic [FL*CR_W-1:0] res_data;
    logic [1:0] core_constr_len;
    logic [K_W-1:0] core_gen_poly [CR_W];
    logic [TB_W-1:0] core_decoder_data_frame;
    logic [CR_W-1:0] enc_data;
    logic enc_done, dec_done;
    logic [FL-1:0] dec_data;

    logic mute = 1'b0;
    logic [1:0] sreg;
    logic [7:0] cap_bits;
    int cap_n;
    int crst_cnt = 0;
    int checks = 0;
    int errors = 0;
    int n;
    int c0;

    endec_job_ctrl #(.CR_W(CR_W), .K_W(K_W), .TB_W(TB_W), .FL(FL), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
        .job_code_rate(job_code_rate), .job_constr_len(job_constr_len),
        .job_gen_poly(job_gen_poly), .job_data(job_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .core_rst_n(core_rst_n), .core_en(core_en), .core_code_rate(core_code_rate),
        .core_constr_len(core_constr_len), .core_gen_poly(core_gen_poly),
        .core_mode_sel(core_mode_sel), .core_encoder_bit(core_encoder_bit),
        .core_decoder_data_frame(core_decoder_data_frame),
        .core_encoder_data(enc_data), .core_encoder_done(enc_done),
        .core_decoder_data(dec_data), .core_decoder_done(dec_done)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [2:0] enc_chunk(input logic b, input logic [1:0] s);
        logic [2:0] r;
        for (int p = 0; p < CR_W; p++) r[p] = ^({b, s} & core_gen_poly[p][2:0]);
        return r;
    endfunction

    // core stub: one cycle per operation, idle for a cycle after each done
    always @(posedge sys_clk) begin
        if (!core_rst_n) begin
            enc_done <= 1'b0; dec_done <= 1'b0; enc_data <= '0; dec_data <= '0;
            sreg <= '0; cap_bits <= '0; cap_n <= 0;
        end else begin
            enc_done <= 1'b0;
            dec_done <= 1'b0;
            if (core_en && !mute && !enc_done && !dec_done) begin
                if (!core_mode_sel) begin
                    enc_done <= 1'b1;
                    enc_data <= enc_chunk(core_encoder_bit, sreg);
                    sreg <= {core_encoder_bit, sreg[1]};
                    cap_bits <= {cap_bits[6:0], core_encoder_bit};
                    cap_n <= cap_n + 1;
                end else begin
                    dec_done <= 1'b1;
                    dec_data <= core_decoder_data_frame[15:8] ^ core_decoder_data_frame[7:0];
                end
            end
        end
    end

    always @(posedge sys_clk) if (rst && !core_rst_n) crst_cnt <= crst_cnt + 1;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic mode, input logic [15:0] data);
        job_mode = mode;
        job_code_rate = 1'b1;
        job_constr_len = 2'd1;
        job_gen_poly = {9'o0, 9'o5, 9'o7};
        job_data = data;
        job_valid = 1'b1;
        chk("job_ready_offer", 32'(job_ready), 1);
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("res_valid_wait", 32'(res_valid), 1);
    endtask

    task automatic finish_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_drop", 32'(res_valid), 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_job_ready", 32'(job_ready), 1);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_err", 32'(res_err), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_core_rst_n", 32'(core_rst_n), 0);
        chk("rst_core_en", 32'(core_en), 0);
        chk("rst_frame", 32'(core_decoder_data_frame), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("idle_core_rst_n", 32'(core_rst_n), 1);

        send(1'b1, 16'b1101101010100110);
        chk("crst_job_ready", 32'(job_ready), 0);
        chk("crst_core_rst_n", 32'(core_rst_n), 0);
        chk("crst_core_en", 32'(core_en), 0);
        chk("cfg_mode", 32'(core_mode_sel), 1);
        chk("cfg_rate", 32'(core_code_rate), 1);
        chk("cfg_len", 32'(core_constr_len), 1);
        chk("cfg_poly0", 32'(core_gen_poly[0]), 7);
        chk("cfg_poly1", 32'(core_gen_poly[1]), 5);
        chk("cfg_frame", 32'(core_decoder_data_frame), 32'hDAA6);
        wait_res(n);
        chk("dec_latency", 32'(n), 3);
        chk("dec_data", 32'(res_data), 32'h7C);
        chk("dec_err", 32'(res_err), 0);
        chk("resp_core_en", 32'(core_en), 0);
        finish_res();
        chk("idle_job_ready", 32'(job_ready), 1);

        send(1'b0, 16'h00B0);
        wait_res(n);
        chk("enc_data", 32'(res_data), 32'h6424C0);
        chk("enc_err", 32'(res_err), 0);
        chk("enc_bits", 32'(cap_bits), 32'hB0);
        chk("enc_nbits", 32'(cap_n), 8);

        job_mode = 1'b1;
        job_data = 16'b1101101010100110;
        job_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 32'(res_valid), 1);
            chk("stall_data", 32'(res_data), 32'h6424C0);
            chk("stall_job_ready", 32'(job_ready), 0);
            chk("stall_mode", 32'(core_mode_sel), 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("b2b_idle_valid", 32'(res_valid), 0);
        chk("b2b_idle_ready", 32'(job_ready), 1);
        c0 = crst_cnt;
        tick();
        job_valid = 1'b0;
        chk("b2b_mode", 32'(core_mode_sel), 1);
        chk("b2b_core_rst_n", 32'(core_rst_n), 0);
        tick();
        chk("b2b_rst_pulse", 32'(crst_cnt - c0), 1);
        chk("b2b_core_en", 32'(core_en), 1);
        wait_res(n);
        chk("b2b_dec_data", 32'(res_data), 32'h7C);
        finish_res();

        mute = 1'b1;
        send(1'b1, 16'hF00F);
        wait_res(n);
        chk("tmo_latency", 32'(n), TIMEOUT + 1);
        chk("tmo_err", 32'(res_err), 1);
        chk("tmo_core_rst_n", 32'(core_rst_n), 0);
        chk("tmo_core_en", 32'(core_en), 0);
        chk("tmo_data", 32'(res_data), 0);
        mute = 1'b0;
        finish_res();
        send(1'b1, 16'hF00F);
        wait_res(n);
        chk("post_tmo_data", 32'(res_data), 32'hFF);
        chk("post_tmo_err", 32'(res_err), 0);
        finish_res();

        send(1'b0, 16'h00B0);
        n = 0;
        while (cap_n < 4 && n < 100) begin
            tick();
            n++;
        end
        chk("mid_enc_bits", 32'(cap_n), 4);
        #2 rst = 1'b0;
        #1;
        chk("arst_job_ready", 32'(job_ready), 1);
        chk("arst_res_valid", 32'(res_valid), 0);
        chk("arst_core_en", 32'(core_en), 0);
        chk("arst_core_rst_n", 32'(core_rst_n), 0);
        chk("arst_res_data", 32'(res_data), 0);
        chk("arst_mode", 32'(core_mode_sel), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_valid", 32'(res_valid), 0);
        chk("post_rst_core_en", 32'(core_en), 0);
        send(1'b0, 16'h00C5);
        wait_res(n);
        chk("enc2_data", 32'(res_data), 32'h6930C8);
        chk("enc2_bits", 32'(cap_bits), 32'hC5);
        chk("enc2_nbits", 32'(cap_n), 8);
        finish_res();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
